// File: rtl/rv32_fib_core.sv
// Single-cycle RV32I-subset core (ADDI, ADD, BEQ, JAL) with a small loadable instruction memory.
// Optional write-back trace outputs are enabled by defining WB_TRACE_EN.
module rv32_fib_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIR_WIDTH  = 5,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_ready,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] alu_result
`ifdef WB_TRACE_EN
  ,
  output logic                  wb_we,
  output logic [DIR_WIDTH-1:0]  wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data
`endif
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);
  localparam int unsigned NREGS = 2 ** DIR_WIDTH;

  typedef enum logic [6:0] {
    OP_ADDI = 7'b0010011,
    OP_ADD  = 7'b0110011,
    OP_BEQ  = 7'b1100011,
    OP_JAL  = 7'b1101111
  } opcode_e;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [IDX_W-1:0]      load_ptr_q, load_ptr_d;
  logic [DATA_WIDTH-1:0] rf_q   [NREGS];
  logic [DATA_WIDTH-1:0] imem_q [IMEM_DEPTH];

  logic [DATA_WIDTH-1:0] instr;
  opcode_e               opcode;
  logic [DIR_WIDTH-1:0]  rd, rs1, rs2;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
  logic [DATA_WIDTH-1:0] imm_i, imm_b, imm_j;
  logic [DATA_WIDTH-1:0] pc_plus4, pc_next, alu, wr_data;
  logic                  wr_en, rf_we, imem_we;

  // Fetch and decode
  always_comb begin
    instr   = prog_ready ? imem_q[pc_q[IDX_W+1:2]] : instruction;
    opcode  = opcode_e'(instr[6:0]);
    rd      = instr[7 +: DIR_WIDTH];
    rs1     = instr[15 +: DIR_WIDTH];
    rs2     = instr[20 +: DIR_WIDTH];
    rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
    rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];
    imm_i   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    imm_b   = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25],
               instr[11:8], 1'b0};
    imm_j   = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20],
               instr[30:21], 1'b0};
  end

  // Execute: ALU, write-back value and next PC
  always_comb begin
    pc_plus4 = pc_q + DATA_WIDTH'(4);
    pc_next  = pc_plus4;
    alu      = '0;
    wr_en    = 1'b0;
    wr_data  = '0;
    case (opcode)
      OP_ADDI: begin
        alu     = rs1_val + imm_i;
        wr_en   = 1'b1;
        wr_data = alu;
      end
      OP_ADD: begin
        alu     = rs1_val + rs2_val;
        wr_en   = 1'b1;
        wr_data = alu;
      end
      OP_BEQ: begin
        alu = rs1_val - rs2_val;
        if (alu == '0) pc_next = pc_q + imm_b;
      end
      OP_JAL: begin
        alu     = pc_plus4;
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        pc_next = pc_q + imm_j;
      end
      default: ;
    endcase
  end

  // A load cycle stalls the core: PC held and no register write
  always_comb begin
    pc_d       = pc_q;
    load_ptr_d = load_ptr_q;
    imem_we    = 1'b0;
    rf_we      = 1'b0;
    if (w_en) begin
      imem_we    = ~rst;
      load_ptr_d = load_ptr_q + IDX_W'(1);
    end else begin
      pc_d  = pc_next;
      rf_we = ~rst & wr_en & (rd != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      load_ptr_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      load_ptr_q <= load_ptr_d;
      if (rf_we) rf_q[rd] <= wr_data;
    end
  end

  // Instruction memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[load_ptr_q] <= instruction;
  end

  assign pc_out     = pc_q;
  assign alu_result = alu;

`ifdef WB_TRACE_EN
  always_comb begin
    wb_we   = rf_we;
    wb_rd   = rf_we ? rd : '0;
    wb_data = rf_we ? wr_data : '0;
  end
`endif

endmodule

// File: tb/tb_rv32_fib_core.sv
// Directed self-checking bench for rv32_fib_core: direct-execute ALU/branch/jump steps,
// reset behaviour, imem load stall, program-mode Fibonacci loop and index/pointer wrap.
module tb_rv32_fib_core;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_ready;
  logic        w_en;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] alu_result;
`ifdef WB_TRACE_EN
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`endif

  int checks   = 0;
  int failures = 0;

  rv32_fib_core #(
    .DATA_WIDTH(32),
    .DIR_WIDTH (5),
    .IMEM_DEPTH(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_ready (prog_ready),
    .w_en       (w_en),
    .instruction(instruction),
    .pc_out     (pc_out),
    .alu_result (alu_result)
`ifdef WB_TRACE_EN
    ,
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [31:0] imm);
    return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] b);
    return {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] j);
    return {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, check the pre-edge state, then advance one cycle
  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] exp_pc,
                      input bit chk_alu, input logic [31:0] exp_alu);
    instruction = ins;
    #1;
    check({tag, "_pc"}, pc_out, exp_pc);
    if (chk_alu) check({tag, "_alu"}, alu_result, exp_alu);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog [6];
    logic [31:0] fib  [5];
    logic [31:0] fib_port;
    logic [31:0] exp_pc;
    int          k;

    fib      = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
    fib_port = enc_jal(5'd0, 32'd256);
    prog[0]  = enc_addi(5'd1, 5'd0, 32'd0);
    prog[1]  = enc_addi(5'd2, 5'd0, 32'd1);
    prog[2]  = enc_add (5'd3, 5'd1, 5'd2);
    prog[3]  = enc_addi(5'd1, 5'd2, 32'd0);
    prog[4]  = enc_addi(5'd2, 5'd3, 32'd0);
    prog[5]  = enc_jal (5'd0, -32'sd12);

    rst = 1'b1; w_en = 1'b0; prog_ready = 1'b0; instruction = NOP;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("nop0", NOP, 32'd0, 1'b1, 32'd0);
    step("nop1", NOP, 32'd4, 1'b0, 32'd0);
    step("nop2", NOP, 32'd8, 1'b0, 32'd0);
    step("addi_x1", 32'h00500093, 32'd12, 1'b1, 32'd5);
    step("addi_x2", 32'hFFD00113, 32'd16, 1'b1, 32'hFFFFFFFD);
    step("add_x3",  32'h002081B3, 32'd20, 1'b1, 32'd2);
    step("rd_x3",   enc_addi(5'd10, 5'd3, 32'd0), 32'd24, 1'b1, 32'd2);
    step("addi_x0", enc_addi(5'd0, 5'd0, 32'd7),  32'd28, 1'b1, 32'd7);
    step("rd_x0",   enc_add(5'd11, 5'd0, 5'd0),   32'd32, 1'b1, 32'd0);
    step("addi_x4", enc_addi(5'd4, 5'd0, 32'd9),  32'd36, 1'b1, 32'd9);
    step("add_x4",  enc_add(5'd4, 5'd0, 5'd0),    32'd40, 1'b1, 32'd0);
    step("rd_x4",   enc_addi(5'd12, 5'd4, 32'd0), 32'd44, 1'b1, 32'd0);
    step("inc_x1a", enc_addi(5'd1, 5'd1, 32'd1),  32'd48, 1'b1, 32'd6);
    step("inc_x1b", enc_addi(5'd1, 5'd1, 32'd1),  32'd52, 1'b1, 32'd7);
    step("addi_x5", enc_addi(5'd5, 5'd0, 32'd7),  32'd56, 1'b1, 32'd7);
    step("jal_to8", enc_jal(5'd0, -32'sd52),      32'd60, 1'b0, 32'd0);

    // x1=7, x2=-3, x5=7
    step("beq_nt",    enc_beq(5'd1, 5'd2, 32'd16), 32'd8,  1'b1, 32'd10);
    step("jal_back",  enc_jal(5'd0, -32'sd4),      32'd12, 1'b0, 32'd0);
    step("beq_t",     enc_beq(5'd1, 5'd5, 32'd16), 32'd8,  1'b1, 32'd0);
    step("jal_back2", enc_jal(5'd0, -32'sd16),     32'd24, 1'b0, 32'd0);
    step("beq_neg",   enc_beq(5'd1, 5'd5, -32'sd8), 32'd8, 1'b1, 32'd0);
    step("jal_fw",    enc_jal(5'd0, 32'd12),       32'd0,  1'b0, 32'd0);
    step("jal_link",  enc_jal(5'd5, 32'd2048),     32'd12, 1'b0, 32'd0);
    step("rd_x5",     enc_addi(5'd13, 5'd5, 32'd0), 32'd2060, 1'b1, 32'd16);
    step("jal_ret",   enc_jal(5'd0, -32'sd2052),   32'd2064, 1'b0, 32'd0);
    step("jal_x0",    enc_jal(5'd0, -32'sd12),     32'd12, 1'b0, 32'd0);
    step("rd_x0b",    enc_addi(5'd14, 5'd0, 32'd0), 32'd0, 1'b1, 32'd0);

    // Reset wins over a simultaneous load and clears the register file
    rst = 1'b1; w_en = 1'b1; instruction = enc_addi(5'd1, 5'd1, 32'd100);
    @(negedge clk);
    rst = 1'b0; w_en = 1'b0;
    step("rst_regs", enc_add(5'd15, 5'd1, 5'd5), 32'd0, 1'b1, 32'd0);
    step("jal_to0",  enc_jal(5'd0, -32'sd4),     32'd4, 1'b0, 32'd0);

    w_en = 1'b1;
    for (int i = 0; i < 6; i++) step("load", prog[i], 32'd0, 1'b0, 32'd0);
    w_en = 1'b0;
    prog_ready = 1'b1;

    exp_pc = 32'd0;
    k = 0;
    for (int n = 0; n < 19; n++) begin
      if (exp_pc == 32'd8) begin
        step("fib", fib_port, exp_pc, 1'b1, fib[k]);
        k++;
      end else begin
        step("fib", fib_port, exp_pc, 1'b0, 32'd0);
      end
      exp_pc = (exp_pc == 32'd20) ? 32'd8 : exp_pc + 32'd4;
    end

    // x1=3, x2=5; pc 264 fetches imem[2] (ADD x3,x1,x2)
    prog_ready = 1'b0;
    step("jal_far", enc_jal(5'd0, 32'd252), 32'd12, 1'b0, 32'd0);
    prog_ready = 1'b1;
    step("wrap_fetch", fib_port, 32'd264, 1'b1, 32'd8);
    step("wrap_next",  fib_port, 32'd268, 1'b1, 32'd5);

    // Load pointer sits at 6: 58 fillers reach the end, the next word lands in imem[0]
    prog_ready = 1'b0;
    w_en = 1'b1;
    for (int i = 0; i < 58; i++) step("fill", NOP, 32'd272, 1'b0, 32'd0);
    step("fill_wrap", enc_addi(5'd7, 5'd0, 32'h123), 32'd272, 1'b0, 32'd0);
    w_en = 1'b0;
    step("stall_nowr", enc_addi(5'd8, 5'd7, 32'd0), 32'd272, 1'b1, 32'd0);
    step("jal_home",   enc_jal(5'd0, -32'sd276),    32'd276, 1'b0, 32'd0);
    prog_ready = 1'b1;
    step("ptr_wrap", fib_port, 32'd0, 1'b1, 32'h123);
    step("after_wrap", fib_port, 32'd4, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
